// File: rtl/ltssm_pkg.sv
// Shared LTSSM encodings: substates seen by RxLTSSM/TxLTSSM, controller states,
// timeout classes and the per-substate timeout/fallback lookups.
package ltssm_pkg;

    typedef enum logic [3:0] {
        SS_DETECT_QUIET   = 4'd0,
        SS_DETECT_ACTIVE  = 4'd1,
        SS_POLLING_ACTIVE = 4'd2,
        SS_POLLING_CONFIG = 4'd3,
        SS_CFG_LW_START   = 4'd4,
        SS_CFG_LW_ACCEPT  = 4'd5,
        SS_CFG_LN_WAIT    = 4'd6,
        SS_CFG_LN_ACCEPT  = 4'd7,
        SS_CFG_COMPLETE   = 4'd8,
        SS_CFG_IDLE       = 4'd9,
        SS_L0             = 4'd10
    } substate_e;

    localparam logic [3:0] LAST_LEGAL_SUBSTATE = 4'd10;

    typedef enum logic [1:0] {
        CTRL_IDLE    = 2'd0,
        CTRL_LAUNCH  = 2'd1,
        CTRL_WAIT    = 2'd2,
        CTRL_RESOLVE = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        LIM_SHORT  = 2'd0,
        LIM_LONG   = 2'd1,
        LIM_DOUBLE = 2'd2,
        LIM_NONE   = 2'd3
    } limit_sel_e;

    function automatic limit_sel_e limit_sel_of(input logic [3:0] ss);
        case (ss)
            SS_DETECT_QUIET:   return LIM_SHORT;
            SS_POLLING_CONFIG: return LIM_DOUBLE;
            SS_L0:             return LIM_NONE;
            default:           return LIM_LONG;
        endcase
    endfunction

    // Only Detect.Quiet escalates forward; every other timeout restarts detection.
    function automatic logic [3:0] fallback_of(input logic [3:0] ss);
        return (ss == SS_DETECT_QUIET) ? 4'(SS_DETECT_ACTIVE) : 4'(SS_DETECT_QUIET);
    endfunction

endpackage

// File: rtl/ltssm_timeout_timer.sv
// Per-substate WAIT timer: cleared on launch, counts enabled cycles and flags the
// cycle whose increment reaches the selected limit.
module ltssm_timeout_timer
    import ltssm_pkg::*;
#(
    parameter int TIMEOUT_SHORT = 12,
    parameter int TIMEOUT_LONG  = 24,
    parameter int TIMER_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic [1:0] limit_sel_i,
    output logic       expired_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;
    logic [TIMER_W-1:0] limit;
    logic               active;

    always_comb begin
        case (limit_sel_i)
            LIM_SHORT:  limit = TIMER_W'(TIMEOUT_SHORT);
            LIM_LONG:   limit = TIMER_W'(TIMEOUT_LONG);
            LIM_DOUBLE: limit = TIMER_W'(2 * TIMEOUT_LONG);
            default:    limit = '0;
        endcase
    end

    // L0 holds the count still so a long stay can never wrap into a false expiry.
    assign active    = enable_i && (limit_sel_i != LIM_NONE);
    assign expired_o = active && ((count_q + TIMER_W'(1)) == limit);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (active) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ltssm_substate_sequencer.sv
// LTSSM top sequencer: launches each substate, collects Rx/Tx finish, applies the
// per-substate timeout fallback and drives linkUp. All outputs are registered.
module ltssm_substate_sequencer
    import ltssm_pkg::*;
#(
    parameter int TIMEOUT_SHORT = 12,
    parameter int TIMEOUT_LONG  = 24,
    parameter int TIMER_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxFinish,
    input  logic [3:0] rxExitTo,
    input  logic       txFinish,
    output logic [3:0] substate,
    output logic       start,
    output logic       forceDetect,
    output logic       exitError,
    output logic       linkUp,
    output logic       timeoutFired
);

    ctrl_state_e state_q, state_d;
    logic [3:0]  substate_q, substate_d;
    logic [3:0]  next_q, next_d;
    logic [3:0]  exit_q, exit_d;
    logic        rx_done_q, rx_done_d;
    logic        tx_done_q, tx_done_d;
    logic        timeout_q, timeout_d;
    logic        start_q, start_d;
    logic        force_q, force_d;
    logic        err_q, err_d;
    logic        link_q, link_d;
    logic        tfired_q, tfired_d;

    logic        timer_clear;
    logic        timer_enable;
    logic        timer_expired;
    logic [1:0]  limit_sel;
    logic        rx_now;
    logic        tx_now;
    logic [3:0]  exit_now;
    logic [3:0]  launch_sub;

    assign limit_sel = limit_sel_of(substate_q);

    ltssm_timeout_timer #(
        .TIMEOUT_SHORT(TIMEOUT_SHORT),
        .TIMEOUT_LONG (TIMEOUT_LONG),
        .TIMER_W      (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (timer_clear),
        .enable_i   (timer_enable),
        .limit_sel_i(limit_sel),
        .expired_o  (timer_expired)
    );

    // A finish arriving this cycle counts as if already latched.
    assign rx_now     = rx_done_q | rxFinish;
    assign tx_now     = tx_done_q | txFinish;
    assign exit_now   = rx_done_q ? exit_q : rxExitTo;
    assign launch_sub = (next_q > LAST_LEGAL_SUBSTATE) ? 4'(SS_DETECT_QUIET) : next_q;

    always_comb begin
        state_d      = state_q;
        substate_d   = substate_q;
        next_d       = next_q;
        exit_d       = exit_q;
        rx_done_d    = rx_done_q;
        tx_done_d    = tx_done_q;
        timeout_d    = timeout_q;
        start_d      = 1'b0;
        force_d      = 1'b0;
        err_d        = 1'b0;
        link_d       = link_q;
        tfired_d     = 1'b0;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;

        case (state_q)
            CTRL_IDLE: begin
                state_d    = CTRL_LAUNCH;
                substate_d = 4'(SS_DETECT_QUIET);
                start_d    = 1'b1;
                link_d     = 1'b0;
            end
            CTRL_LAUNCH: begin
                rx_done_d   = 1'b0;
                tx_done_d   = 1'b0;
                timer_clear = 1'b1;
                state_d     = CTRL_WAIT;
            end
            CTRL_WAIT: begin
                timer_enable = 1'b1;
                // Completion is checked first so it beats a same-cycle expiry.
                if (rx_now && tx_now) begin
                    state_d   = CTRL_RESOLVE;
                    next_d    = exit_now;
                    timeout_d = 1'b0;
                    err_d     = (exit_now > LAST_LEGAL_SUBSTATE);
                end else begin
                    if (rxFinish && !rx_done_q) begin
                        rx_done_d = 1'b1;
                        exit_d    = rxExitTo;
                    end
                    if (txFinish) begin
                        tx_done_d = 1'b1;
                    end
                    if (timer_expired) begin
                        state_d   = CTRL_RESOLVE;
                        next_d    = fallback_of(substate_q);
                        timeout_d = 1'b1;
                        tfired_d  = 1'b1;
                    end
                end
            end
            CTRL_RESOLVE: begin
                state_d    = CTRL_LAUNCH;
                substate_d = launch_sub;
                start_d    = 1'b1;
                force_d    = timeout_q;
                link_d     = (launch_sub == SS_L0);
            end
            default: begin
                state_d = CTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CTRL_IDLE;
            substate_q <= '0;
            next_q     <= '0;
            exit_q     <= '0;
            rx_done_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            timeout_q  <= 1'b0;
            start_q    <= 1'b0;
            force_q    <= 1'b0;
            err_q      <= 1'b0;
            link_q     <= 1'b0;
            tfired_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            substate_q <= substate_d;
            next_q     <= next_d;
            exit_q     <= exit_d;
            rx_done_q  <= rx_done_d;
            tx_done_q  <= tx_done_d;
            timeout_q  <= timeout_d;
            start_q    <= start_d;
            force_q    <= force_d;
            err_q      <= err_d;
            link_q     <= link_d;
            tfired_q   <= tfired_d;
        end
    end

    assign substate     = substate_q;
    assign start        = start_q;
    assign forceDetect  = force_q;
    assign exitError    = err_q;
    assign linkUp       = link_q;
    assign timeoutFired = tfired_q;

endmodule

// File: tb/tb_ltssm_substate_sequencer.sv
// Bench for ltssm_substate_sequencer: a timeline model (offsets from each launch)
// predicts every output each cycle; directed scenarios add literal expectations.
module tb_ltssm_substate_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxFinish;
    logic [3:0] rxExitTo;
    logic       txFinish;
    logic [3:0] substate;
    logic       start;
    logic       forceDetect;
    logic       exitError;
    logic       linkUp;
    logic       timeoutFired;

    always #5 clk = ~clk;

    ltssm_substate_sequencer #(
        .TIMEOUT_SHORT(12),
        .TIMEOUT_LONG (24),
        .TIMER_W      (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rxFinish    (rxFinish),
        .rxExitTo    (rxExitTo),
        .txFinish    (txFinish),
        .substate    (substate),
        .start       (start),
        .forceDetect (forceDetect),
        .exitError   (exitError),
        .linkUp      (linkUp),
        .timeoutFired(timeoutFired)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Model: m_off = cycles since the current substate's launch cycle (-1 = idle after reset),
    // m_end = offset of the cycle that decided the exit; launch follows two cycles later.
    int m_off     = -1;
    int m_end     = -2;
    bit m_decided = 1'b1;
    bit m_rx_seen = 1'b0;
    bit m_tx_seen = 1'b0;
    bit m_force   = 1'b0;
    bit m_to      = 1'b0;
    bit m_err     = 1'b0;
    int m_sub     = 0;
    int m_next    = 0;
    int m_exit    = 0;

    logic res_to;
    logic res_err;

    function automatic int limit_of(input int s);
        if (s == 0)  return 12;
        if (s == 3)  return 48;
        if (s == 10) return 0;
        return 24;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_off = -1; m_end = -2; m_decided = 1'b1;
            m_next = 0; m_to = 1'b0; m_err = 1'b0; m_force = 1'b0; m_sub = 0;
            m_rx_seen = 1'b0; m_tx_seen = 1'b0;
        end else begin
            if (m_off >= 1 && !m_decided) begin
                if (rxFinish && !m_rx_seen) begin
                    m_rx_seen = 1'b1;
                    m_exit = int'(rxExitTo);
                end
                if (txFinish) m_tx_seen = 1'b1;
                if (m_rx_seen && m_tx_seen) begin
                    m_decided = 1'b1; m_end = m_off; m_to = 1'b0;
                    m_err  = (m_exit > 10);
                    m_next = (m_exit > 10) ? 0 : m_exit;
                end else if (limit_of(m_sub) != 0 && m_off == limit_of(m_sub)) begin
                    m_decided = 1'b1; m_end = m_off; m_to = 1'b1; m_err = 1'b0;
                    m_next = (m_sub == 0) ? 1 : 0;
                end
            end
            m_off++;
            if (m_decided && m_off == m_end + 2) begin
                m_off = 0; m_force = m_to; m_sub = m_next; m_decided = 1'b0;
                m_rx_seen = 1'b0; m_tx_seen = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("substate", substate, 4'(m_sub));
            check("start", {3'b000, start}, 4'(m_off == 0));
            check("forceDetect", {3'b000, forceDetect}, 4'(m_off == 0 && m_force));
            check("linkUp", {3'b000, linkUp}, 4'(m_sub == 10));
            check("timeoutFired", {3'b000, timeoutFired},
                  4'(m_decided && m_off == m_end + 1 && m_to));
            check("exitError", {3'b000, exitError},
                  4'(m_decided && m_off == m_end + 1 && m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Called in a launch cycle; ends in the next launch cycle with RESOLVE outputs captured.
    task automatic run_sub(input int rx_off, input int ex, input int tx_off);
        int last;
        last = (rx_off > tx_off) ? rx_off : tx_off;
        for (int o = 0; o <= last; o++) begin
            rxFinish = (o == rx_off);
            txFinish = (o == tx_off);
            rxExitTo = 4'(ex);
            tick();
        end
        rxFinish = 1'b0;
        txFinish = 1'b0;
        res_to   = timeoutFired;
        res_err  = exitError;
        tick();
    endtask

    task automatic run_timeout(input int lim);
        rxFinish = 1'b0;
        txFinish = 1'b0;
        for (int o = 0; o <= lim; o++) tick();
        res_to  = timeoutFired;
        res_err = exitError;
        tick();
    endtask

    initial begin
        reset = 1'b1; rxFinish = 1'b0; txFinish = 1'b0; rxExitTo = 4'd0;
        tick();
        cmp_en = 1'b1;
        tick(); tick();
        check("rst_start", {3'b000, start}, 4'd0);
        check("rst_substate", substate, 4'd0);
        check("rst_linkUp", {3'b000, linkUp}, 4'd0);
        check("rst_timeoutFired", {3'b000, timeoutFired}, 4'd0);

        reset = 1'b0;
        tick();
        check("first_start", {3'b000, start}, 4'd1);
        check("first_substate", substate, 4'd0);

        // Detect.Quiet expiry escalates to Detect.Active.
        run_timeout(12);
        check("dq_timeoutFired", {3'b000, res_to}, 4'd1);
        check("dq_next_substate", substate, 4'd1);
        check("dq_forceDetect", {3'b000, forceDetect}, 4'd1);

        run_sub(1, 2, 1);
        check("da_to_pa", substate, 4'd2);
        check("da_no_force", {3'b000, forceDetect}, 4'd0);

        run_sub(2, 3, 5);
        check("pa_no_timeout", {3'b000, res_to}, 4'd0);
        check("pa_to_pc", substate, 4'd3);
        check("pa_start", {3'b000, start}, 4'd1);

        run_sub(3, 4, 1);
        check("pc_to_cfg", substate, 4'd4);
        for (int s = 5; s <= 10; s++) begin
            run_sub(1, s, 2);
            check("walk_substate", substate, 4'(s));
            check("walk_linkUp", {3'b000, linkUp}, 4'(s == 10));
        end
        repeat (100) tick();
        check("l0_hold_substate", substate, 4'd10);
        check("l0_hold_linkUp", {3'b000, linkUp}, 4'd1);

        run_sub(1, 13, 1);
        check("illegal_exitError", {3'b000, res_err}, 4'd1);
        check("illegal_no_timeout", {3'b000, res_to}, 4'd0);
        check("illegal_to_dq", substate, 4'd0);

        run_sub(1, 3, 1);
        run_sub(48, 5, 48);
        check("pc_edge_no_timeout", {3'b000, res_to}, 4'd0);
        check("pc_edge_substate", substate, 4'd5);

        run_sub(1, 3, 1);
        run_timeout(48);
        check("pc_timeout", {3'b000, res_to}, 4'd1);
        check("pc_timeout_to_dq", substate, 4'd0);

        // Same-substate re-entry must restart the full Detect.Quiet window.
        run_sub(1, 0, 1);
        check("reentry_substate", substate, 4'd0);
        check("reentry_start", {3'b000, start}, 4'd1);
        run_timeout(12);
        check("reentry_timeout_to_da", substate, 4'd1);

        run_sub(1, 10, 1);
        check("to_l0_linkUp", {3'b000, linkUp}, 4'd1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("l0_reset_linkUp", {3'b000, linkUp}, 4'd0);
        check("l0_reset_substate", substate, 4'd0);
        reset = 1'b0;
        tick();
        check("restart_start", {3'b000, start}, 4'd1);
        check("restart_substate", substate, 4'd0);

        // A latched rxFinish must not survive reset.
        tick();
        rxFinish = 1'b1; rxExitTo = 4'd2;
        tick();
        rxFinish = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        txFinish = 1'b1;
        tick();
        txFinish = 1'b0;
        repeat (11) tick();
        check("latch_discard_timeout", {3'b000, timeoutFired}, 4'd1);
        tick();
        check("latch_discard_substate", substate, 4'd1);

        for (int i = 0; i < 4000; i++) begin
            rxFinish = ($urandom_range(0, 5) == 0);
            txFinish = ($urandom_range(0, 5) == 0);
            rxExitTo = 4'($urandom_range(0, 12));
            reset    = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0; rxFinish = 1'b0; txFinish = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
